stable_matching_seq: RTL

- Sequential Gale-Shapley engine. Performs one proposal per clock, so the preference datapath is reused every cycle instead of being unrolled into S*S-S+2 stages.
- Sequences its own proposal/accept/reject step with a small FSM over registered state: proposal counts, match flags and the match list.
- Produces the same match-list output format as the unrolled combinational matcher.
- Drop-in sequential alternative for large S where the unrolled netlist is too big.

---
 rtl/stable_matching_seq_if.sv | 31 +++
 rtl/stable_matching_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/stable_matching_seq_if.sv
// Handshake and result bundle for the sequential Gale-Shapley matcher.
// The controller drives start/g; the engine returns status and matches.
interface stable_matching_seq_if #(
    parameter int S  = 4,
    parameter int R  = 4,
    parameter int Ks = 4,
    parameter int Kr = 4
);
    localparam int LOG_S = $clog2(S);
    localparam int LOG_R = $clog2(R);
    localparam int G_W   = R * Kr * LOG_S + S * Ks * LOG_R;
    localparam int SCW   = $clog2(S * Ks + 1);

    logic                 start;
    logic [G_W-1:0]       g;
    logic                 busy;
    logic                 done;
    logic [R*LOG_S:0]     o;
    logic [R-1:0]         r_matched;
    logic [SCW-1:0]       step_count;

    modport master (
        output start, g,
        input  busy, done, o, r_matched, step_count
    );

    modport slave (
        input  start, g,
        output busy, done, o, r_matched, step_count
    );
endinterface

// File: rtl/stable_matching_seq.sv
// Sequential Gale-Shapley matcher: one proposal per clock over
// registered preference lists, proposal counters and the match list.
module stable_matching_seq #(
    parameter int S  = 4,
    parameter int R  = 4,
    parameter int Ks = 4,
    parameter int Kr = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    stable_matching_seq_if.slave  bus
);
    localparam int LOG_S = $clog2(S);
    localparam int LOG_R = $clog2(R);
    localparam int PCW   = $clog2(Ks + 1);
    localparam int RKW   = $clog2(Kr + 1);
    localparam int SCW   = $clog2(S * Ks + 1);
    localparam int SP_BASE = R * Kr * LOG_S;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_n;

    logic [Kr-1:0][LOG_S-1:0] r_pref [R];
    logic [Ks-1:0][LOG_R-1:0] s_pref [S];
    logic [PCW-1:0]           pc [S];
    logic [S-1:0]             s_match;
    logic [R-1:0]             r_match;
    logic [R-1:0][LOG_S-1:0]  match_list;
    logic [SCW-1:0]           steps;

    logic                     have_p;
    logic [LOG_S-1:0]         p;
    logic [PCW-1:0]           off;
    logic [LOG_R-1:0]         tgt;
    logic                     tgt_ok;
    logic                     tgt_taken;
    logic [LOG_S-1:0]         s1;
    logic [Kr-1:0][LOG_S-1:0] tgt_row;
    logic [RKW-1:0]           rank_p;
    logic [RKW-1:0]           rank_s1;
    logic                     better;

    // Proposer select, target lookup and receiver-side ranking.
    always_comb begin
        have_p = 1'b0;
        p      = '0;
        for (int s = S - 1; s >= 0; s--) begin
            if (pc[s] != '0 && !s_match[s]) begin
                have_p = 1'b1;
                p      = LOG_S'(s);
            end
        end
        off = PCW'(Ks) - pc[p];
        tgt = '0;
        for (int j = 0; j < Ks; j++) begin
            if (off == PCW'(j)) tgt = s_pref[p][j];
        end
        tgt_ok    = int'(tgt) < R;
        tgt_taken = 1'b0;
        s1        = '0;
        tgt_row   = '0;
        for (int r = 0; r < R; r++) begin
            if (tgt == LOG_R'(r)) begin
                tgt_taken = r_match[r];
                s1        = match_list[r];
                tgt_row   = r_pref[r];
            end
        end
        // Scan downward so the lowest matching slot wins.
        rank_p  = RKW'(Kr);
        rank_s1 = RKW'(Kr);
        for (int j = Kr - 1; j >= 0; j--) begin
            if (tgt_row[j] == p)  rank_p  = RKW'(j);
            if (tgt_row[j] == s1) rank_s1 = RKW'(j);
        end
        better = rank_p < rank_s1;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.start) state_n = RUN;
            RUN:     if (!have_p)   state_n = DONE;
            DONE:    if (bus.start) state_n = RUN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < R; i++) r_pref[i] <= '0;
            for (int i = 0; i < S; i++) s_pref[i] <= '0;
            for (int i = 0; i < S; i++) pc[i] <= '0;
            s_match    <= '0;
            r_match    <= '0;
            match_list <= '0;
            steps      <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        for (int i = 0; i < R; i++)
                            for (int j = 0; j < Kr; j++)
                                r_pref[i][j] <=
                                    bus.g[LOG_S*(Kr*i+j) +: LOG_S];
                        for (int i = 0; i < S; i++)
                            for (int j = 0; j < Ks; j++)
                                s_pref[i][j] <=
                                    bus.g[SP_BASE+LOG_R*(Ks*i+j) +: LOG_R];
                        for (int i = 0; i < S; i++) pc[i] <= PCW'(Ks);
                        s_match    <= '0;
                        r_match    <= '0;
                        match_list <= '0;
                        steps      <= '0;
                    end
                end
                RUN: begin
                    if (have_p) begin
                        pc[p] <= pc[p] - PCW'(1);
                        steps <= steps + SCW'(1);
                        for (int r = 0; r < R; r++) begin
                            if (tgt_ok && tgt == LOG_R'(r)) begin
                                if (!tgt_taken) begin
                                    match_list[r] <= p;
                                    r_match[r]    <= 1'b1;
                                    s_match[p]    <= 1'b1;
                                end else if (better) begin
                                    match_list[r] <= p;
                                    s_match[p]    <= 1'b1;
                                    s_match[s1]   <= 1'b0;
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = state == RUN;
    assign bus.done       = state == DONE;
    assign bus.o          = {state == DONE, match_list};
    assign bus.r_matched  = r_match;
    assign bus.step_count = steps;
endmodule
